// File: rtl/ysyx_25060170_gpr_wb_arb_if.sv
// Write-back request channel: one source (EXU or LSU) presents a register write and
// holds it until the arbiter returns ready.
interface ysyx_25060170_gpr_wb_arb_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
    logic          ready;

    modport master (output valid, output rd, output wd, input ready);
    modport slave  (input valid, input rd, input wd, output ready);
endinterface

// File: rtl/ysyx_25060170_gpr_wb_arb.sv
// Round-robin arbiter for the GPR write port (EXU vs LSU) with a busy-bit scoreboard
// that stalls issue on RAW/WAW hazards until the pending write has landed.
module ysyx_25060170_gpr_wb_arb #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid_i,
    input  logic                issue_wen_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic [AW-1:0]       issue_rs1_i,
    input  logic [AW-1:0]       issue_rs2_i,
    output logic                issue_ready_o,
    ysyx_25060170_gpr_wb_arb_if.slave exu,
    ysyx_25060170_gpr_wb_arb_if.slave lsu,
    output logic                gpr_we_o,
    output logic [AW-1:0]       gpr_writer_o,
    output logic [DW-1:0]       gpr_wd_o,
    output logic [2**AW-1:0]    busy_o,
    output logic                sb_err_o
);
    logic                rr_q;
    logic                grant_exu;
    logic                grant_lsu;
    logic                grant_any;
    logic [AW-1:0]       grant_rd;
    logic [DW-1:0]       grant_wd;
    logic                issue_fire;
    logic [2**AW-1:0]    busy_q;
    logic [2**AW-1:0]    busy_d;
    logic                err_q;
    logic                err_d;
    logic                gpr_we_q;
    logic [AW-1:0]       gpr_writer_q;
    logic [DW-1:0]       gpr_wd_q;

    // rr_q = 1 means the LSU wins a tie.
    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst) begin
            if (exu.valid && lsu.valid) begin
                grant_exu = !rr_q;
                grant_lsu = rr_q;
            end else begin
                grant_exu = exu.valid;
                grant_lsu = lsu.valid;
            end
        end
    end

    assign grant_any = grant_exu | grant_lsu;
    assign grant_rd  = grant_lsu ? lsu.rd : exu.rd;
    assign grant_wd  = grant_lsu ? lsu.wd : exu.wd;
    assign exu.ready = grant_exu;
    assign lsu.ready = grant_lsu;

    assign issue_ready_o = rst | !(busy_q[issue_rs1_i] | busy_q[issue_rs2_i]
                                   | (issue_wen_i & busy_q[issue_rd_i]));
    assign issue_fire    = issue_valid_i & issue_ready_o;

    // Clear first, then set, so a same-edge set of the retiring index wins.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (gpr_we_q) begin
            if (!busy_q[gpr_writer_q]) begin
                err_d = 1'b1;
            end
            busy_d[gpr_writer_q] = 1'b0;
        end
        if (issue_fire && issue_wen_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= 1'b0;
            busy_q       <= '0;
            err_q        <= 1'b0;
            gpr_we_q     <= 1'b0;
            gpr_writer_q <= '0;
            gpr_wd_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            err_q    <= err_d;
            gpr_we_q <= grant_any && (grant_rd != '0);
            if (grant_any) begin
                rr_q         <= grant_exu;
                gpr_writer_q <= grant_rd;
                gpr_wd_q     <= grant_wd;
            end
        end
    end

    assign gpr_we_o     = gpr_we_q;
    assign gpr_writer_o = gpr_writer_q;
    assign gpr_wd_o     = gpr_wd_q;
    assign busy_o       = busy_q;
    assign sb_err_o     = err_q;
endmodule

// File: tb/tb_ysyx_25060170_gpr_wb_arb.sv
// Bench for the GPR write-back arbiter: directed vector table, hand sequences,
// then random traffic against a behavioural model.
module tb_ysyx_25060170_gpr_wb_arb;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid_i;
    logic          issue_wen_i;
    logic [AW-1:0] issue_rd_i;
    logic [AW-1:0] issue_rs1_i;
    logic [AW-1:0] issue_rs2_i;
    logic          issue_ready_o;
    logic          gpr_we_o;
    logic [AW-1:0] gpr_writer_o;
    logic [DW-1:0] gpr_wd_o;
    logic [31:0]   busy_o;
    logic          sb_err_o;

    ysyx_25060170_gpr_wb_arb_if #(.DW(DW), .AW(AW)) exu_if ();
    ysyx_25060170_gpr_wb_arb_if #(.DW(DW), .AW(AW)) lsu_if ();

    ysyx_25060170_gpr_wb_arb #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid_i(issue_valid_i),
        .issue_wen_i  (issue_wen_i),
        .issue_rd_i   (issue_rd_i),
        .issue_rs1_i  (issue_rs1_i),
        .issue_rs2_i  (issue_rs2_i),
        .issue_ready_o(issue_ready_o),
        .exu          (exu_if.slave),
        .lsu          (lsu_if.slave),
        .gpr_we_o     (gpr_we_o),
        .gpr_writer_o (gpr_writer_o),
        .gpr_wd_o     (gpr_wd_o),
        .busy_o       (busy_o),
        .sb_err_o     (sb_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        iv;
        bit        iw;
        bit [4:0]  ird;
        bit [4:0]  irs1;
        bit [4:0]  irs2;
        bit        ev;
        bit [4:0]  erd;
        bit [31:0] ewd;
        bit        lv;
        bit [4:0]  lrd;
        bit [31:0] lwd;
        bit        x_ir;
        bit        x_er;
        bit        x_lr;
        bit        x_we;
        bit [4:0]  x_wr;
        bit [31:0] x_wd;
        bit [31:0] x_busy;
        bit        x_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit iv, bit iw, bit [4:0] ird, bit [4:0] irs1,
                                bit [4:0] irs2, bit ev, bit [4:0] erd, bit [31:0] ewd,
                                bit lv, bit [4:0] lrd, bit [31:0] lwd, bit x_ir, bit x_er,
                                bit x_lr, bit x_we, bit [4:0] x_wr, bit [31:0] x_wd,
                                bit [31:0] x_busy, bit x_err);
        vec_t v;
        v.rst = r;    v.iv = iv;     v.iw = iw;     v.ird = ird;  v.irs1 = irs1;
        v.irs2 = irs2; v.ev = ev;    v.erd = erd;   v.ewd = ewd;  v.lv = lv;
        v.lrd = lrd;  v.lwd = lwd;   v.x_ir = x_ir; v.x_er = x_er; v.x_lr = x_lr;
        v.x_we = x_we; v.x_wr = x_wr; v.x_wd = x_wd; v.x_busy = x_busy; v.x_err = x_err;
        return v;
    endfunction

    task automatic drive(input bit r, input bit iv, input bit iw, input bit [4:0] ird,
                         input bit [4:0] irs1, input bit [4:0] irs2, input bit ev,
                         input bit [4:0] erd, input bit [31:0] ewd, input bit lv,
                         input bit [4:0] lrd, input bit [31:0] lwd);
        rst           = r;
        issue_valid_i = iv;
        issue_wen_i   = iw;
        issue_rd_i    = ird;
        issue_rs1_i   = irs1;
        issue_rs2_i   = irs2;
        exu_if.valid  = ev;
        exu_if.rd     = erd;
        exu_if.wd     = ewd;
        lsu_if.valid  = lv;
        lsu_if.rd     = lrd;
        lsu_if.wd     = lwd;
    endtask

    // Entered and left at posedge+1.
    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.rst, v.iv, v.iw, v.ird, v.irs1, v.irs2, v.ev, v.erd, v.ewd, v.lv, v.lrd,
              v.lwd);
        @(negedge clk);
        check("vec issue_ready", idx, 32'(issue_ready_o), 32'(v.x_ir));
        check("vec exu_ready", idx, 32'(exu_if.ready), 32'(v.x_er));
        check("vec lsu_ready", idx, 32'(lsu_if.ready), 32'(v.x_lr));
        @(posedge clk);
        #1;
        check("vec gpr_we", idx, 32'(gpr_we_o), 32'(v.x_we));
        check("vec gpr_writer", idx, 32'(gpr_writer_o), 32'(v.x_wr));
        check("vec gpr_wd", idx, gpr_wd_o, v.x_wd);
        check("vec busy", idx, busy_o, v.x_busy);
        check("vec sb_err", idx, 32'(sb_err_o), 32'(v.x_err));
    endtask

    // Model state: busy set, who won last, the one write sitting on the port.
    bit [31:0] m_busy;
    int        m_last;
    bit        m_we;
    bit [4:0]  m_wr;
    bit [31:0] m_wd;
    bit        m_err;

    task automatic random_phase(input int cycles);
        bit [4:0]  pool[$];
        bit        eh = 1'b0;
        bit        lh = 1'b0;
        bit [4:0]  erd_r = '0;
        bit [4:0]  lrd_r = '0;
        bit [31:0] ewd_r = '0;
        bit [31:0] lwd_r = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            bit r;
            bit iv;
            bit iw;
            bit [4:0] ird;
            bit [4:0] rs1;
            bit [4:0] rs2;
            bit exp_ir;
            bit ge;
            bit gl;
            r = (cyc < 2) || ($urandom_range(0, 499) == 0);
            if (!eh && $urandom_range(0, 1) == 1) begin
                if (pool.size() > 0) begin
                    eh = 1'b1; erd_r = pool.pop_front(); ewd_r = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    eh = 1'b1; erd_r = '0; ewd_r = $urandom;
                end
            end
            if (!lh && $urandom_range(0, 1) == 1) begin
                if (pool.size() > 0) begin
                    lh = 1'b1; lrd_r = pool.pop_front(); lwd_r = $urandom;
                end else if ($urandom_range(0, 7) == 0) begin
                    lh = 1'b1; lrd_r = '0; lwd_r = $urandom;
                end
            end
            iv  = 1'($urandom_range(0, 1));
            iw  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            drive(r, iv, iw, ird, rs1, rs2, eh, erd_r, ewd_r, lh, lrd_r, lwd_r);
            @(negedge clk);
            if (r) begin
                exp_ir = 1'b1; ge = 1'b0; gl = 1'b0;
            end else begin
                exp_ir = !(m_busy[rs1] || m_busy[rs2] || (iw && m_busy[ird]));
                if (eh && lh) begin
                    ge = (m_last == 1);
                    gl = !ge;
                end else begin
                    ge = eh;
                    gl = lh;
                end
            end
            check("rnd issue_ready", cyc, 32'(issue_ready_o), 32'(exp_ir));
            check("rnd exu_ready", cyc, 32'(exu_if.ready), 32'(ge));
            check("rnd lsu_ready", cyc, 32'(lsu_if.ready), 32'(gl));
            if (r) begin
                m_busy = '0; m_last = 1; m_we = 1'b0; m_wr = '0; m_wd = '0; m_err = 1'b0;
                pool.delete();
                eh = 1'b0;
                lh = 1'b0;
            end else begin
                if (m_we) begin
                    if (!m_busy[m_wr]) m_err = 1'b1;
                    m_busy[m_wr] = 1'b0;
                end
                if (iv && exp_ir && iw && ird != 0) begin
                    m_busy[ird] = 1'b1;
                    pool.push_back(ird);
                end
                if (ge) begin
                    m_we = (erd_r != 0); m_wr = erd_r; m_wd = ewd_r; m_last = 0; eh = 1'b0;
                end else if (gl) begin
                    m_we = (lrd_r != 0); m_wr = lrd_r; m_wd = lwd_r; m_last = 1; lh = 1'b0;
                end else begin
                    m_we = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            check("rnd gpr_we", cyc, 32'(gpr_we_o), 32'(m_we));
            check("rnd gpr_writer", cyc, 32'(gpr_writer_o), 32'(m_wr));
            check("rnd gpr_wd", cyc, gpr_wd_o, m_wd);
            check("rnd busy", cyc, busy_o, m_busy);
            check("rnd sb_err", cyc, 32'(sb_err_o), 32'(m_err));
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset with both held, round-robin with back-to-back pairs, idle stall check.
        vecs.push_back(mk(1, 0,0,0,0,0, 1,3,'h11, 1,4,'h22, 1,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0,0,0, 1,3,'h11, 1,4,'h22, 1,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0, 1,1,3,0,0, 1,3,'h11, 1,4,'h22, 1,1,0, 1,3,'h11,'h8,0));
        vecs.push_back(mk(0, 1,1,4,0,0, 1,3,'h33, 1,4,'h22, 1,0,1, 1,4,'h22,'h10,0));
        vecs.push_back(mk(0, 1,1,3,0,0, 1,3,'h33, 1,4,'h44, 1,1,0, 1,3,'h33,'h8,0));
        vecs.push_back(mk(0, 1,1,4,0,0, 0,0,0, 1,4,'h44, 1,0,1, 1,4,'h44,'h10,0));
        vecs.push_back(mk(0, 0,0,0,4,0, 0,0,0, 0,0,0, 0,0,0, 0,4,'h44,0,0));
        // Single write to x5.
        vecs.push_back(mk(0, 1,1,5,0,0, 0,0,0, 0,0,0, 1,0,0, 0,4,'h44,'h20,0));
        vecs.push_back(mk(0, 0,0,0,0,0, 1,5,'hDEADBEEF, 0,0,0, 1,1,0,
                          1,5,'hDEADBEEF,'h20,0));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,5,'hDEADBEEF,0,0));
        // RAW on x7.
        vecs.push_back(mk(0, 1,1,7,0,0, 0,0,0, 0,0,0, 1,0,0, 0,5,'hDEADBEEF,'h80,0));
        vecs.push_back(mk(0, 1,0,0,7,0, 1,7,'h77, 0,0,0, 0,1,0, 1,7,'h77,'h80,0));
        vecs.push_back(mk(0, 1,0,0,7,0, 0,0,0, 0,0,0, 0,0,0, 0,7,'h77,0,0));
        vecs.push_back(mk(0, 1,0,0,7,0, 0,0,0, 0,0,0, 1,0,0, 0,7,'h77,0,0));
        // WAW on x7.
        vecs.push_back(mk(0, 1,1,7,0,0, 0,0,0, 0,0,0, 1,0,0, 0,7,'h77,'h80,0));
        vecs.push_back(mk(0, 1,1,7,0,0, 0,0,0, 1,7,'h78, 0,0,1, 1,7,'h78,'h80,0));
        vecs.push_back(mk(0, 1,1,7,0,0, 0,0,0, 0,0,0, 0,0,0, 0,7,'h78,0,0));
        vecs.push_back(mk(0, 1,1,7,0,0, 0,0,0, 0,0,0, 1,0,0, 0,7,'h78,'h80,0));
        // x0 issue and x0 write.
        vecs.push_back(mk(0, 1,1,0,0,0, 0,0,0, 1,0,'hFFFFFFFF, 1,0,1,
                          0,0,'hFFFFFFFF,'h80,0));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,0,'hFFFFFFFF,'h80,0));
        // Retire of x9 colliding with a new issue of x9.
        vecs.push_back(mk(0, 0,0,0,0,0, 1,9,'h99, 0,0,0, 1,1,0, 1,9,'h99,'h80,0));
        vecs.push_back(mk(0, 1,1,9,0,0, 0,0,0, 0,0,0, 1,0,0, 0,9,'h99,'h280,1));
        vecs.push_back(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,9,'h99,'h280,1));
        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Reset while a write to x6 sits on the port.
        apply_vec(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,0,0,0,0), 100);
        apply_vec(mk(0, 1,1,6,0,0, 0,0,0, 0,0,0, 1,0,0, 0,0,0,'h40,0), 101);
        apply_vec(mk(0, 0,0,0,0,0, 1,6,'h66, 0,0,0, 1,1,0, 1,6,'h66,'h40,0), 102);
        apply_vec(mk(1, 0,0,0,0,0, 1,6,'h66, 0,0,0, 1,0,0, 0,0,0,0,0), 103);
        apply_vec(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,0,0,0,0), 104);
        // Write to non-busy x12 raises a sticky error.
        apply_vec(mk(0, 0,0,0,0,0, 1,12,'h12, 0,0,0, 1,1,0, 1,12,'h12,0,0), 105);
        apply_vec(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,12,'h12,0,1), 106);
        apply_vec(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,12,'h12,0,1), 107);
        apply_vec(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,12,'h12,0,1), 108);

        random_phase(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25060170_gpr_wb_arb.md
# ysyx_25060170_gpr_wb_arb

Write-back arbiter and register scoreboard for the core's 32×32 general-purpose register file. It shares the file's single write port between two write-back sources, the EXU (ALU results) and the LSU (load data), using round-robin arbitration. It drives that port from registered outputs. It also keeps a per-register busy bitmap and holds off instruction issue on RAW and WAW hazards until the pending write has landed in the register file.

## Interface
Parameters:
- `DW`, 32, write-data width
- `AW`, 5, register index width (2^AW registers; x0 hard-wired zero)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `issue_valid_i`  in  1  IDU presents an instruction
- `issue_wen_i`  in  1  instruction writes `issue_rd_i`
- `issue_rd_i`  in  AW  destination register
- `issue_rs1_i`, `issue_rs2_i`  in  AW  source registers
- `issue_ready_o`  out  1  no hazard; issue handshake = `issue_valid_i & issue_ready_o`
- `exu_valid_i`  in  1  EXU write request
- `exu_rd_i`  in  AW  EXU target register
- `exu_wd_i`  in  DW  EXU write data
- `exu_ready_o`  out  1  EXU request granted this cycle
- `lsu_valid_i`, `lsu_rd_i`, `lsu_wd_i`, `lsu_ready_o`  same as EXU, for the LSU
- `gpr_we_o`  out  1  register-file write enable (registered)
- `gpr_writer_o`  out  AW  register-file target (registered)
- `gpr_wd_o`  out  DW  register-file write data (registered)
- `busy_o`  out  2^AW  scoreboard bitmap; bit 0 is always 0
- `sb_err_o`  out  1  sticky flag: a write retired to a register that was not busy

## Operation
- **Arbiter:** combinational grant from the two valid inputs and the 1-bit pointer `rr_q`.
  - One valid: that source is granted.
  - Both valid: EXU is granted if `rr_q=0`, LSU if `rr_q=1`.
  - On any grant, `rr_q` flips so the non-granted source gets priority next. After an EXU grant `rr_q←1`; after an LSU grant `rr_q←0`.
  - `exu_ready_o` / `lsu_ready_o` is high only for the granted source. Exactly one grant per cycle is possible; the arbiter never back-pressures a lone requester.
- **Requester rule:** a requester holds valid, rd and wd stable until ready. A violation is a protocol error; the block does not check it.
- **Write register:** on a grant, the next edge loads `gpr_we_o←(rd!=0)`, `gpr_writer_o←rd`, `gpr_wd_o←wd`. With no grant, the next edge loads `gpr_we_o←0`; writer and data hold their values.
- **Scoreboard:**
  - Issue handshake with `issue_wen_i=1` and `issue_rd_i!=0` sets `busy[issue_rd_i]` at the edge.
  - A cycle with `gpr_we_o=1` clears `busy[gpr_writer_o]` at the edge. This is the same edge at which the register file captures the data.
  - Set and clear of the same index at the same edge: set wins, so busy stays 1.
  - `busy[0]` is never set.
  - A clear where `busy[gpr_writer_o]` is already 0 sets `sb_err_o`, which clears only on reset.
- **Issue gate:** `issue_ready_o = !(busy[rs1] | busy[rs2] | (issue_wen_i & busy[rd]))`. This is combinational and depends on no valid input.
- **x0 rule:** requests with rd=0 are granted normally but produce `gpr_we_o=0` and do not touch the scoreboard.

## Timing
- **Reset values:** `gpr_we_o=0`, `gpr_writer_o=0`, `gpr_wd_o=0`, `busy_o=0`, `sb_err_o=0`, `rr_q=0`.
- **During reset:** `exu_ready_o=0`, `lsu_ready_o=0`, `issue_ready_o=1`.
- **Reset mid-operation:** every in-flight write and busy bit is discarded. Requesters re-present their requests after reset.
- **Grant-to-port latency:** one cycle. A grant in cycle t gives `gpr_we_o=1` in cycle t+1, and the register file holds the value from the end of t+1.
- **Busy clear:** the bit reads 0 from cycle t+2. A dependent issue can therefore handshake at t+2 at the earliest and then reads the new value combinationally.
- **Busy set:** an issue handshake in cycle i gives `busy[rd]=1` from cycle i+1.
- **Throughput:** one write per cycle sustained. Under continuous dual requests, grants alternate strictly EXU, LSU, EXU, …

## Test plan
- **Reset:** hold `rst` 2 cycles with both sources valid → all outputs at reset values, both readies 0. The first grant after release goes to EXU.
- **Single write:** issue rd=5 (busy_o[5]=1 next cycle); EXU valid rd=5 wd=0xDEADBEEF at t → exu_ready_o=1 at t; gpr_we_o=1, writer=5, wd=0xDEADBEEF at t+1; busy_o[5]=0 and sb_err_o=0 at t+2.
- **Round-robin:** EXU (rd=3, 0x11) and LSU (rd=4, 0x22) held valid from reset release → port writes 3/0x11, then 4/0x22. With a second pair presented immediately, the port writes 3, then 4, with no idle cycle.
- **RAW stall:** issue rd=7; next instruction rs1=7 → issue_ready_o=0 until the cycle after gpr_we_o=1 for x7, then 1. A WAW issue with rd=7 behaves the same way.
- **x0:** issue wen rd=0 → busy_o unchanged. LSU write rd=0 wd=0xFFFFFFFF → lsu_ready_o=1, gpr_we_o stays 0, sb_err_o stays 0.
- **Collision and error:** a write retiring x9 at the same edge as a new issue of rd=9 → busy_o[9]=1 afterwards. A separate EXU write to non-busy x12 → sb_err_o=1, held until reset.
